// File: rtl/pad_stream_writer_if.sv
// Interior input stream plus registered memory write port of the padded stream writer.
interface pad_stream_writer_if #(
   parameter int unsigned PE     = 16,
   parameter int unsigned ADDR_W = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [PE*8-1:0]     in_data;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [PE*8-1:0]     wr_data;

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/pad_stream_writer.sv
// Sweeps a padded (H+2P)x(W+2P)xCG tensor in raster order, writing pad words
// for border positions and consuming the interior stream for the rest.
module pad_stream_writer #(
   parameter int unsigned PE      = 16,
   parameter int unsigned DIM_W   = 8,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned MAX_PAD = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [DIM_W-1:0]    cfg_h,
   input  logic [DIM_W-1:0]    cfg_w,
   input  logic [DIM_W-1:0]    cfg_cg,
   input  logic [1:0]          cfg_pad,
   input  logic [7:0]          cfg_pad_val,
   input  logic [ADDR_W-1:0]   cfg_base,
   pad_stream_writer_if.slave  bus,
   output logic                busy,
   output logic                done
);

   localparam int unsigned DW = PE * 8;
   // Row/column counters need room for H+2*MAX_PAD
   localparam int unsigned CW = DIM_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_PAD, S_DATA, S_FLUSH} state_t;

   state_t state_q, state_d;

   logic [CW-1:0]     pad_q, row_hi_q, col_hi_q, rows_q, cols_q;
   logic [DIM_W-1:0]  cg_q;
   logic [DW-1:0]     pad_word_q;

   logic [CW-1:0]     row_q, col_q;
   logic [DIM_W-1:0]  grp_q;
   logic [ADDR_W-1:0] addr_q;

   logic              wr_en_q, done_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DW-1:0]     wr_data_q;

   logic [1:0]        pad_in;
   logic              zero_dims, accept;
   logic              emit, ready_c;
   logic              last_grp, last_col, last_row, is_last, nxt_interior;
   logic [CW-1:0]     nxt_row, nxt_col;
   logic [DIM_W-1:0]  nxt_grp;
   state_t            step_state;

   always_comb begin
      pad_in    = (32'(cfg_pad) > MAX_PAD) ? 2'(MAX_PAD) : cfg_pad;
      zero_dims = (cfg_h == '0) || (cfg_w == '0) || (cfg_cg == '0);
      accept    = (state_q == S_IDLE) && start;
   end

   always_comb begin
      last_grp = (grp_q == cg_q - DIM_W'(1));
      last_col = (col_q == cols_q - CW'(1));
      last_row = (row_q == rows_q - CW'(1));
      is_last  = last_grp && last_col && last_row;
      nxt_grp  = grp_q + DIM_W'(1);
      nxt_col  = col_q;
      nxt_row  = row_q;
      if (last_grp) begin
         nxt_grp = '0;
         if (last_col) begin
            nxt_col = '0;
            nxt_row = row_q + CW'(1);
         end else begin
            nxt_col = col_q + CW'(1);
         end
      end
      nxt_interior = (nxt_row >= pad_q) && (nxt_row < row_hi_q) &&
                     (nxt_col >= pad_q) && (nxt_col < col_hi_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      emit       = 1'b0;
      ready_c    = 1'b0;
      step_state = is_last ? S_FLUSH : (nxt_interior ? S_DATA : S_PAD);
      case (state_q)
         S_IDLE: begin
            // Position (0,0) is interior only when there is no padding
            if (start) begin
               if (zero_dims)          state_d = S_FLUSH;
               else if (pad_in == '0)  state_d = S_DATA;
               else                    state_d = S_PAD;
            end
         end
         S_PAD: begin
            emit    = 1'b1;
            state_d = step_state;
         end
         S_DATA: begin
            ready_c = 1'b1;
            if (bus.in_valid) begin
               emit    = 1'b1;
               state_d = step_state;
            end
         end
         S_FLUSH: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pad_q      <= '0;
         row_hi_q   <= '0;
         col_hi_q   <= '0;
         rows_q     <= '0;
         cols_q     <= '0;
         cg_q       <= '0;
         pad_word_q <= '0;
      end else if (accept) begin
         pad_q      <= CW'(pad_in);
         row_hi_q   <= CW'(cfg_h) + CW'(pad_in);
         col_hi_q   <= CW'(cfg_w) + CW'(pad_in);
         rows_q     <= CW'(cfg_h) + CW'({pad_in, 1'b0});
         cols_q     <= CW'(cfg_w) + CW'({pad_in, 1'b0});
         cg_q       <= cfg_cg;
         pad_word_q <= {PE{cfg_pad_val}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q  <= '0;
         col_q  <= '0;
         grp_q  <= '0;
         addr_q <= '0;
      end else if (accept) begin
         row_q  <= '0;
         col_q  <= '0;
         grp_q  <= '0;
         addr_q <= cfg_base;
      end else if (emit) begin
         row_q  <= nxt_row;
         col_q  <= nxt_col;
         grp_q  <= nxt_grp;
         addr_q <= addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         wr_en_q <= emit;
         done_q  <= (state_q == S_FLUSH);
         if (emit) begin
            wr_addr_q <= addr_q;
            wr_data_q <= (state_q == S_PAD) ? pad_word_q : bus.in_data;
         end
      end
   end

   assign bus.in_ready = ready_c;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;

endmodule

// File: tb/tb_pad_stream_writer.sv
// Directed bench for pad_stream_writer: padded sweeps, stalls, pass-through,
// empty tensor, ignored restart and mid-tensor reset.
module tb_pad_stream_writer;

   localparam int unsigned PE     = 16;
   localparam int unsigned DIM_W  = 8;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DW     = PE * 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [DIM_W-1:0]   cfg_h, cfg_w, cfg_cg;
   logic [1:0]         cfg_pad;
   logic [7:0]         cfg_pad_val;
   logic [ADDR_W-1:0]  cfg_base;
   logic               busy, done;

   pad_stream_writer_if #(.PE(PE), .ADDR_W(ADDR_W)) bus ();

   pad_stream_writer #(
      .PE(PE), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .MAX_PAD(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_cg(cfg_cg), .cfg_pad(cfg_pad),
      .cfg_pad_val(cfg_pad_val), .cfg_base(cfg_base),
      .bus(bus), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [ADDR_W-1:0] wa_q[$];
   logic [DW-1:0]     wd_q[$];
   int                wc_q[$];
   int                done_cnt = 0;
   int                done_cyc = 0;
   logic              done_busy = 1'b0;

   always @(negedge clk) begin
      if (bus.wr_en) begin
         wa_q.push_back(bus.wr_addr);
         wd_q.push_back(bus.wr_data);
         wc_q.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_busy = busy;
      end
   end

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] words[16];
   logic [DW-1:0] exp_d[64];
   int t_start_cyc, t_stall_ready, t_ready_low;
   bit t_aborted;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_exp(input logic [7:0] pv);
      for (int i = 0; i < 64; i++) exp_d[i] = {PE{pv}};
   endtask

   task automatic run_tensor(input int h, input int w, input int cg, input int pad,
                             input logic [7:0] pv, input logic [ADDR_W-1:0] base,
                             input int nwords, input int stall_ptr, input int stall_n,
                             input int abort_after, input bit restart);
      int ptr, stalled, n0, d0;
      bit hs;
      ptr = 0; stalled = 0; hs = 1'b0;
      n0 = wa_q.size(); d0 = done_cnt;
      t_stall_ready = 0; t_ready_low = 0; t_aborted = 1'b0;
      @(negedge clk); #1;
      cfg_h = DIM_W'(h); cfg_w = DIM_W'(w); cfg_cg = DIM_W'(cg); cfg_pad = 2'(pad);
      cfg_pad_val = pv; cfg_base = base;
      bus.in_valid = 1'b0;
      start = 1'b1;
      t_start_cyc = cyc;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #1;
         start = restart && (i == 0);
         // Config churn while busy must not disturb the latched tensor
         cfg_h = 8'd7; cfg_w = 8'd6; cfg_cg = 8'd3; cfg_pad = 2'd2;
         cfg_pad_val = 8'h5A; cfg_base = 32'hDEAD0000;
         if (hs) ptr++;
         if (done_cnt != d0) break;
         if (abort_after > 0 && wa_q.size() - n0 >= abort_after) begin
            rst_n = 1'b0;
            t_aborted = 1'b1;
            break;
         end
         if (ptr == stall_ptr && stalled < stall_n) begin
            bus.in_valid = 1'b0;
            stalled++;
            if (bus.in_ready) t_stall_ready++;
         end else begin
            bus.in_valid = (ptr < nwords);
         end
         bus.in_data = words[ptr < 16 ? ptr : 0];
         if (busy && !bus.in_ready && ptr < nwords) t_ready_low++;
         hs = bus.in_ready && bus.in_valid;
      end
      bus.in_valid = 1'b0;
      start = 1'b0;
      if (!t_aborted) chk("done_seen", done_cnt - d0, 1);
   endtask

   task automatic check_seq(input string tag, input int n0, input int cnt,
                            input logic [ADDR_W-1:0] base, input int span, input bit chk_done);
      int last;
      chk({tag, "_count"}, wa_q.size() - n0, cnt);
      for (int k = 0; k < cnt && n0 + k < wa_q.size(); k++) begin
         chk({tag, "_addr"}, wa_q[n0 + k], base + ADDR_W'(k));
         chk({tag, "_data"}, wd_q[n0 + k], exp_d[k]);
      end
      if (wa_q.size() > n0) begin
         last = wa_q.size() - 1;
         chk({tag, "_first_latency"}, wc_q[n0] - t_start_cyc, 2);
         chk({tag, "_span"}, wc_q[last] - wc_q[n0], span);
         if (chk_done) begin
            chk({tag, "_done_cycle"}, done_cyc, wc_q[last] + 1);
            chk({tag, "_busy_at_done"}, done_busy, 0);
         end
      end
   endtask

   initial begin
      int n0, d0;
      cfg_h = '0; cfg_w = '0; cfg_cg = '0; cfg_pad = '0; cfg_pad_val = '0; cfg_base = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      for (int i = 0; i < 16; i++) words[i] = {4{32'hC0DE0000 | 32'(i)}};

      // Reset state and quiet after release
      repeat (3) @(negedge clk);
      #1;
      chk("reset_ctrl", {bus.wr_en, bus.in_ready, busy, done}, 0);
      chk("reset_addr", bus.wr_addr, 0);
      chk("reset_data", bus.wr_data, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("idle_no_writes", wa_q.size(), 0);
      chk("idle_ctrl", {bus.wr_en, bus.in_ready, busy, done}, 0);

      // 2x2x1, P=1: A,B,C,D at 5,6,9,10
      fill_exp(8'h00);
      exp_d[5] = words[0]; exp_d[6] = words[1]; exp_d[9] = words[2]; exp_d[10] = words[3];
      n0 = wa_q.size();
      run_tensor(2, 2, 1, 1, 8'h00, 32'h0, 4, 0, 0, 0, 1'b0);
      check_seq("basic", n0, 16, 32'h0, 15, 1'b1);

      // Same tensor, 3-cycle stall before B
      n0 = wa_q.size();
      run_tensor(2, 2, 1, 1, 8'h00, 32'h0, 4, 1, 3, 0, 1'b0);
      check_seq("stall", n0, 16, 32'h0, 18, 1'b1);
      chk("stall_ready_high", t_stall_ready, 3);

      // 1x1x2, P=2, pad 0x80, base 0x100: data at 0x118/0x119
      fill_exp(8'h80);
      exp_d[24] = words[0]; exp_d[25] = words[1];
      n0 = wa_q.size();
      run_tensor(1, 1, 2, 2, 8'h80, 32'h100, 2, 0, 0, 0, 1'b0);
      check_seq("pad2", n0, 50, 32'h100, 49, 1'b1);

      // P=0 pass-through, 2x3x1
      fill_exp(8'h00);
      for (int i = 0; i < 6; i++) exp_d[i] = words[i];
      n0 = wa_q.size();
      run_tensor(2, 3, 1, 0, 8'h33, 32'h20, 6, 0, 0, 0, 1'b0);
      check_seq("passthru", n0, 6, 32'h20, 5, 1'b1);
      chk("passthru_ready_low", t_ready_low, 0);

      // Empty tensor, with a second start while busy
      n0 = wa_q.size();
      d0 = done_cnt;
      run_tensor(2, 0, 1, 1, 8'h00, 32'h40, 0, 0, 0, 0, 1'b1);
      chk("empty_done_lat", done_cyc - t_start_cyc, 2);
      repeat (30) @(negedge clk);
      #1;
      chk("empty_no_writes", wa_q.size() - n0, 0);
      chk("empty_one_done", done_cnt - d0, 1);
      chk("empty_idle", busy, 0);

      // Reset after 7 writes, then a full rerun from address 0
      fill_exp(8'h00);
      exp_d[5] = words[0]; exp_d[6] = words[1]; exp_d[9] = words[2]; exp_d[10] = words[3];
      n0 = wa_q.size();
      run_tensor(2, 2, 1, 1, 8'h00, 32'h0, 4, 0, 0, 7, 1'b0);
      chk("abort_taken", t_aborted, 1);
      #1;
      chk("abort_ctrl", {bus.wr_en, bus.in_ready, busy, done}, 0);
      chk("abort_addr", bus.wr_addr, 0);
      chk("abort_data", bus.wr_data, 0);
      check_seq("abort_part", n0, 7, 32'h0, 6, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      n0 = wa_q.size();
      repeat (5) @(negedge clk);
      #1;
      chk("post_reset_quiet", wa_q.size() - n0, 0);
      run_tensor(2, 2, 1, 1, 8'h00, 32'h0, 4, 0, 0, 0, 1'b0);
      check_seq("rerun", n0, 16, 32'h0, 15, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
